// File: rtl/secded_checker.sv
// secded_checker
//
// Syndrome-check and single-bit-correct stage for the 39-bit SECDED codeword
// path. It computes the Hamming syndrome and the overall parity of each
// received word and corrects any single-bit error. Uncorrectable words are
// flagged and passed through unmodified. Words travel through a 2-stage
// valid/ready pipeline, and saturating counters track delivered errors.
//
// Codeword layout: index i (0..37) is Hamming position i+1. Check bits sit at
// indices 0,1,3,7,15,31. Index 38 is overall even parity over bits 0..37.
//
// Ports:
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   in_valid      in_code is valid
//   in_ready      block accepts in_code this cycle
//   in_code       received 39-bit codeword
//   out_valid     out_* are valid
//   out_ready     consumer accepts out_* this cycle
//   out_code      corrected codeword (same index layout as in_code)
//   out_syndrome  Hamming syndrome of the delivered word
//   out_sbe       single-bit error detected and corrected
//   out_dbe       uncorrectable error, out_code is unmodified
//   cnt_clr       synchronous clear of both error counters
//   sbe_count     delivered words with out_sbe (saturating)
//   dbe_count     delivered words with out_dbe (saturating)

module secded_checker #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [38:0]      in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [38:0]      out_code,
    output logic [5:0]       out_syndrome,
    output logic             out_sbe,
    output logic             out_dbe,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] sbe_count,
    output logic [CNT_W-1:0] dbe_count
);

    // Stage 1 holding registers
    logic        v1;
    logic [38:0] code1;
    logic [5:0]  syn1;
    logic        par1;

    logic        adv1;
    logic        adv2;

    logic [5:0]  syn_in;
    logic        par_in;

    logic [38:0] flip_mask;
    logic [38:0] corr_code;
    logic        corr_sbe;
    logic        corr_dbe;

    // A stage can load when it is empty or when the stage after it drains
    // this cycle. in_ready does not depend on in_valid.
    assign adv2     = !out_valid || out_ready;
    assign adv1     = !v1 || adv2;
    assign in_ready = adv1;

    // Syndrome bit k is the parity of every Hamming position that has bit k
    // set. The overall parity also covers bit 38.
    always_comb begin
        syn_in = '0;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 38; i++) begin
                if ((((i + 1) >> k) & 1) != 0) begin
                    syn_in[k] = syn_in[k] ^ in_code[i];
                end
            end
        end
        par_in = ^in_code;
    end

    // Stage 1 captures the raw word with its syndrome and parity. Only the
    // valid bit is cleared when no word arrives, so the data path is not
    // toggled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            code1 <= '0;
            syn1  <= '0;
            par1  <= 1'b0;
        end else if (adv1) begin
            v1 <= in_valid;
            if (in_valid) begin
                code1 <= in_code;
                syn1  <= syn_in;
                par1  <= par_in;
            end
        end
    end

    // Classify and build a one-hot flip mask. A parity error with a zero
    // syndrome means bit 38 itself flipped. A parity error with a syndrome
    // beyond 38 points outside the codeword, so it cannot be a single-bit
    // error. A non-zero syndrome with good parity means an even number of flips.
    always_comb begin
        flip_mask = '0;
        corr_sbe  = 1'b0;
        corr_dbe  = 1'b0;
        if (par1) begin
            if (syn1 == 6'd0) begin
                flip_mask[38] = 1'b1;
                corr_sbe      = 1'b1;
            end else if (syn1 <= 6'd38) begin
                for (int i = 0; i < 38; i++) begin
                    if (syn1 == 6'(i + 1)) begin
                        flip_mask[i] = 1'b1;
                    end
                end
                corr_sbe = 1'b1;
            end else begin
                corr_dbe = 1'b1;
            end
        end else if (syn1 != 6'd0) begin
            corr_dbe = 1'b1;
        end
        corr_code = code1 ^ flip_mask;
    end

    // Stage 2 drives the output ports directly. The result fields load only
    // with a real word, so they keep their last values while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_code     <= '0;
            out_syndrome <= '0;
            out_sbe      <= 1'b0;
            out_dbe      <= 1'b0;
        end else if (adv2) begin
            out_valid <= v1;
            if (v1) begin
                out_code     <= corr_code;
                out_syndrome <= syn1;
                out_sbe      <= corr_sbe;
                out_dbe      <= corr_dbe;
            end
        end
    end

    // Error counters count only delivered words and stick at all-ones.
    // A clear beats an increment in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sbe_count <= '0;
            dbe_count <= '0;
        end else if (cnt_clr) begin
            sbe_count <= '0;
            dbe_count <= '0;
        end else if (out_valid && out_ready) begin
            if (out_sbe && (sbe_count != '1)) begin
                sbe_count <= sbe_count + CNT_W'(1);
            end
            if (out_dbe && (dbe_count != '1)) begin
                dbe_count <= dbe_count + CNT_W'(1);
            end
        end
    end

endmodule
